// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: LANES sbox lanes walk a 128-bit state in 16/LANES cycles.
// Ports: clk, rst, in_valid/in_ready/state_in, out_valid/out_ready/state_out, busy.

module sbox #(
  parameter int ROM_WIDTH = 20
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  if (ROM_WIDTH < 1) begin : g_bad_rom
    $error("sbox: ROM_WIDTH must be positive");
  end

  function automatic logic [7:0] gmul(input logic [7:0] x,
                                      input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    p = x;
    for (int i = 0; i < 6; i++) p = gmul(gmul(p, p), x);
    return gmul(p, p);
  endfunction

  logic [7:0] b;

  always_comb begin
    b = ginv(a);
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
          ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

module sub_bytes_seq #(
  parameter int LANES     = 4,
  parameter int ROM_WIDTH = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [7:0]    src [16];
  logic [7:0]    res [16];
  logic [3:0]    base;
  logic          last;
  logic [7:0]    lin  [LANES];
  logic [7:0]    lout [LANES];

  // first byte handled this cycle; wraps harmlessly for LANES=16 (cnt=0)
  assign base = 4'(cnt) * 4'(LANES);
  assign last = (cnt == CW'(N - 1));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lin[k] = src[base + 4'(k)];
    sbox #(.ROM_WIDTH(ROM_WIDTH)) u_sbox (
      .a(lin[k]),
      .y(lout[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= '0;
      for (int i = 0; i < 16; i++) begin
        src[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++)
              src[i] <= state_in[127-8*i -: 8];
            cnt <= '0;
            st  <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < LANES; k++)
            res[base + 4'(k)] <= lout[k];
          if (last) begin
            cnt <= '0;
            st  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_out
    assign state_out[127-8*i -: 8] = res[i];
  end

  assign in_ready  = (st == IDLE) && !rst;
  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Testbench for sub_bytes_seq: directed vectors, LANES sweep, random stream.
// Instance 0 is LANES=4; instances 1..4 are LANES=1,2,8,16.

module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic [4:0]   ir;
  logic [4:0]   ov;
  logic [4:0]   bz;
  logic [127:0] so [5];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 :
                       (g == 2) ? 2 : (g == 3) ? 8 : 16;
    sub_bytes_seq #(.LANES(L), .ROM_WIDTH(20)) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(ir[g]),
      .state_in(state_in),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .state_out(so[g]),
      .busy(bz[g])
    );
  end

  logic [7:0] sb [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = sb[s[127-8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", ir[0], 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // one transaction on instance 0 with out_ready held high
  task automatic xfer(input logic [127:0] s,
                      input logic [127:0] e,
                      input string tag);
    int lat;
    chk({tag, "_ready_pre"}, ir[0], 1'b1);
    state_in  = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    state_in = ~s;
    lat = 1;
    while (!ov[0] && lat < 40) begin
      chk({tag, "_busy"}, bz[0], 1'b1);
      chk({tag, "_ready_run"}, ir[0], 1'b0);
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_ready_done"}, ir[0], 1'b0);
    chk({tag, "_data"}, so[0], e);
    step();
    chk({tag, "_ov_drop"}, ov[0], 1'b0);
    chk({tag, "_ready_back"}, ir[0], 1'b1);
  endtask

  localparam logic [127:0] V1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E1 = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic [127:0] exp_q [$];
  logic [127:0] hold;
  int first [5];
  logic [127:0] cap [5];
  int lat_exp [5] = '{5, 17, 9, 3, 2};

  initial begin
    do_reset();
    chk("reset_ov", ov[0], 1'b0);
    chk("reset_busy", bz[0], 1'b0);
    chk("reset_out", so[0], '0);
    chk("reset_ready", ir[0], 1'b1);

    xfer(V1, E1, "fips");
    xfer(128'h000102030405060708090a0b0c0d0e0f,
         128'h637c777bf26b6fc53001672bfed7ab76, "bytemap");
    xfer({16{8'hff}}, {16{8'h16}}, "all_ff");
    xfer(128'h000000c2_00000000_00000000_00000000,
         128'h636363_25_63636363_63636363_63636363, "byte3");

    // backpressure
    out_ready = 1'b0;
    state_in  = V1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_ov", ov[0], 1'b1);
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      state_in = 128'h0f0e0d0c0b0a09080706050403020100;
      step();
      chk("bp_hold", so[0], E1);
      chk("bp_ov_hold", ov[0], 1'b1);
      chk("bp_ready", ir[0], 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_ov", ov[0], 1'b0);
    chk("bp_release_ready", ir[0], 1'b1);
    step();
    chk("bp_no_capture", bz[0], 1'b0);

    // reset in the second RUN cycle
    state_in = 128'h00112233445566778899aabbccddeeff;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ir[0], 1'b0);
    step();
    rst = 1'b0;
    chk("mid_rst_ov", ov[0], 1'b0);
    chk("mid_rst_busy", bz[0], 1'b0);
    chk("mid_rst_out", so[0], '0);
    #1;
    xfer(V1, E1, "after_rst");

    // rst wins over in_valid
    rst = 1'b1;
    in_valid = 1'b1;
    state_in = V1;
    #1;
    chk("rst_iv_ready", ir[0], 1'b0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_iv_busy", bz[0], 1'b0);

    // LANES sweep, all instances start together
    do_reset();
    out_ready = 1'b1;
    state_in  = V1;
    in_valid  = 1'b1;
    for (int g = 0; g < 5; g++) begin
      first[g] = 0;
      cap[g]   = '0;
    end
    step();
    in_valid = 1'b0;
    state_in = '0;
    for (int c = 1; c < 25; c++) begin
      for (int g = 0; g < 5; g++)
        if (ov[g] && first[g] == 0) begin
          first[g] = c;
          cap[g]   = so[g];
        end
      step();
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("sweep%0d_lat", g), first[g], lat_exp[g]);
      chk($sformatf("sweep%0d_data", g), cap[g], E1);
    end

    // random stream on instance 0
    do_reset();
    fork
      begin
        logic [127:0] s;
        int t;
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) step();
          s = {$urandom, $urandom, $urandom, $urandom};
          state_in = s;
          in_valid = 1'b1;
          t = 0;
          while (!ir[0] && t < 200) begin
            step();
            t++;
          end
          chk("rnd_accept", ir[0], 1'b1);
          exp_q.push_back(ref_sub(s));
          step();
          in_valid = 1'b0;
          state_in = ~s;
        end
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 20 && cyc < 3000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (ov[0] && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("rnd_extra", exp_q.size(), 1);
            end else begin
              hold = exp_q.pop_front();
              chk($sformatf("rnd%0d", got), so[0], hold);
            end
            got++;
          end
          step();
          cyc++;
        end
        chk("rnd_count", got, 20);
      end
    join
    out_ready = 1'b1;
    repeat (10) step();
    chk("rnd_no_dup", ov[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
